// File: rtl/tftlcd_pkg.sv
// Shared constants for the direction-button conditioner: channel indices and
// the per-channel debounce FSM state encoding.
package tftlcd_pkg;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_UP    = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_RIGHT = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_DB   = 3'd1,
    ST_HELD       = 3'd2,
    ST_REPEAT     = 3'd3,
    ST_RELEASE_DB = 3'd4
  } btn_state_e;

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debounce/auto-repeat FSM and its
// saturating counter. Auto-repeat is compiled in only when AUTO_REPEAT_EN is defined.
//
//  state         | meaning
//  --------------+-----------------------------------------------------------
//  ST_IDLE       | released and stable
//  ST_PRESS_DB   | press seen, waiting for DB_CYCLES stable-pressed cycles
//  ST_HELD       | debounced press, waiting REPEAT_DELAY for first repeat
//  ST_REPEAT     | auto-repeating every REPEAT_PERIOD cycles
//  ST_RELEASE_DB | release seen, waiting for DB_CYCLES stable-released cycles
module btn_channel
  import tftlcd_pkg::*;
#(
  parameter int DB_CYCLES     = 90000,
  parameter int REPEAT_DELAY  = 4500000,
  parameter int REPEAT_PERIOD = 900000,
  parameter int CNT_W         = 23
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_in,
  output logic pulse,
  output logic level_nxt
);

`ifdef AUTO_REPEAT_EN
  localparam bit AUTO_RPT = 1'b1;
`else
  localparam bit AUTO_RPT = 1'b0;
`endif

  // The IDLE/HELD cycle that first sees the new level counts as stable cycle
  // one, so the debounce window ends one count early.
  localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DB_CYCLES - 2);
  localparam logic [CNT_W-1:0] RPT_DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             sync_q1;
  logic             sync;
  btn_state_e       state;
  btn_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             db_done;
  logic             dly_done;
  logic             per_done;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q1 <= 1'b0;
      sync    <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      sync    <= sync_q1;
    end
  end

  assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
  assign db_done  = (cnt == DB_LAST);
  assign dly_done = (cnt == RPT_DLY_LAST);
  assign per_done = (cnt == RPT_PER_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (sync) begin
          state_nxt = ST_PRESS_DB;
          cnt_nxt   = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!sync) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (db_done) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_HELD: begin
        if (!sync) begin
          state_nxt = ST_RELEASE_DB;
          cnt_nxt   = '0;
        end else if (AUTO_RPT && dly_done) begin
          state_nxt = ST_REPEAT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_REPEAT: begin
        if (!sync) begin
          state_nxt = ST_RELEASE_DB;
          cnt_nxt   = '0;
        end else if (per_done) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      ST_RELEASE_DB: begin
        if (sync) begin
          state_nxt = ST_HELD;
          cnt_nxt   = '0;
        end else if (db_done) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pulse and level are presented one cycle early; the top registers them.
  always_comb begin
    pulse = 1'b0;
    case (state)
      ST_PRESS_DB: pulse = sync && db_done;
      ST_HELD:     pulse = AUTO_RPT && sync && dly_done;
      ST_REPEAT:   pulse = sync && per_done;
      default:     pulse = 1'b0;
    endcase
    level_nxt = (state_nxt == ST_HELD) || (state_nxt == ST_REPEAT) ||
                (state_nxt == ST_RELEASE_DB);
  end

endmodule

// File: rtl/dir_button_conditioner.sv
// Direction push-button conditioner feeding the rgb pattern Move_* inputs.
// Auto-repeat is enabled by defining AUTO_REPEAT_EN; default build is one pulse per press.
module dir_button_conditioner
  import tftlcd_pkg::*;
#(
  parameter int NUM_BTN       = 4,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int DB_CYCLES     = 90000,
  parameter int REPEAT_DELAY  = 4500000,
  parameter int REPEAT_PERIOD = 900000,
  parameter int CNT_W         = 23
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] move_pulse,
  output logic [NUM_BTN-1:0] btn_level
);

  logic [NUM_BTN-1:0] btn_norm;
  logic [NUM_BTN-1:0] pulse_raw;
  logic [NUM_BTN-1:0] pulse_arb;
  logic [NUM_BTN-1:0] level_nxt;

  assign btn_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_channel #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .CNT_W         (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rstn      (rstn),
      .btn_in    (btn_norm[i]),
      .pulse     (pulse_raw[i]),
      .level_nxt (level_nxt[i])
    );
  end

  // Opposing directions in the same cycle cancel; orthogonal ones pass together.
  always_comb begin
    pulse_arb = pulse_raw;
    if (pulse_raw[BTN_LEFT] && pulse_raw[BTN_RIGHT]) begin
      pulse_arb[BTN_LEFT]  = 1'b0;
      pulse_arb[BTN_RIGHT] = 1'b0;
    end
    if (pulse_raw[BTN_UP] && pulse_raw[BTN_DOWN]) begin
      pulse_arb[BTN_UP]   = 1'b0;
      pulse_arb[BTN_DOWN] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      move_pulse <= '0;
      btn_level  <= '0;
    end else begin
      move_pulse <= pulse_arb;
      btn_level  <= level_nxt;
    end
  end

endmodule

// File: tb/tb_dir_button_conditioner.sv
// Directed bench for dir_button_conditioner with DB_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8; repeat expectations follow whether AUTO_REPEAT_EN is defined.
module tb_dir_button_conditioner;

`ifdef AUTO_REPEAT_EN
  localparam bit AUTO_RPT = 1'b1;
`else
  localparam bit AUTO_RPT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] btn_raw;
  logic [3:0] move_pulse;
  logic [3:0] btn_level;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  dir_button_conditioner #(
    .NUM_BTN       (4),
    .ACTIVE_LOW    (1'b0),
    .DB_CYCLES     (4),
    .REPEAT_DELAY  (20),
    .REPEAT_PERIOD (8),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .btn_raw    (btn_raw),
    .move_pulse (move_pulse),
    .btn_level  (btn_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Pulse schedule for a button held from step 0: first press at +6,
  // then (auto-repeat only) +26 and every 8 cycles after.
  function automatic bit exp_rpt(int i);
    if (i == 6) return 1'b1;
    if (AUTO_RPT && i >= 26 && ((i - 26) % 8) == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic release_all();
    btn_raw = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step();
      check("release_pulse", move_pulse, 4'b0000);
    end
    check("release_level", btn_level, 4'b0000);
  endtask

  initial begin
    rstn    = 1'b1;
    btn_raw = 4'b0000;
    #2;
    rstn    = 1'b0;
    btn_raw = 4'hF;

    // Reset held with all buttons pressed
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_pulse", move_pulse, 4'b0000);
      check("rst_level", btn_level, 4'b0000);
    end
    rstn = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) step();
      check("post_rst_pulse", move_pulse, 4'b0000);
      check("post_rst_level", btn_level, (i == 6) ? 4'hF : 4'h0);
    end
    release_all();

    // Clean Up press held 6 cycles
    btn_raw = 4'b0010;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("up_pulse", move_pulse, (i == 6) ? 4'b0010 : 4'b0000);
      check("up_level", btn_level, (i == 6) ? 4'b0010 : 4'b0000);
    end
    btn_raw = 4'b0000;
    step();
    check("up_single", move_pulse, 4'b0000);
    release_all();

    // Bouncing Left: 1,0,1,0 then held
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      step();
      check("bounce_pulse", move_pulse, 4'b0000);
      check("bounce_level", btn_level, 4'b0000);
    end
    btn_raw = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("bounce_final_pulse", move_pulse, (i == 6) ? 4'b0001 : 4'b0000);
      check("bounce_final_level", btn_level, (i >= 6) ? 4'b0001 : 4'b0000);
    end
    release_all();

    // Right held 60 cycles
    btn_raw = 4'b1000;
    for (int i = 1; i <= 60; i++) begin
      step();
      check("right_hold_pulse", move_pulse, exp_rpt(i) ? 4'b1000 : 4'b0000);
    end
    release_all();

    // Left+Right cancel; Up+Right pass together
    btn_raw = 4'b1001;
    for (int i = 1; i <= 7; i++) begin
      step();
      check("lr_cancel_pulse", move_pulse, 4'b0000);
      check("lr_level", btn_level, (i >= 6) ? 4'b1001 : 4'b0000);
    end
    release_all();
    btn_raw = 4'b1010;
    for (int i = 1; i <= 7; i++) begin
      step();
      check("ur_pulse", move_pulse, (i == 6) ? 4'b1010 : 4'b0000);
    end
    release_all();

    // Down held 60 cycles, then a 2-cycle release glitch
    btn_raw = 4'b0100;
    for (int i = 1; i <= 60; i++) begin
      step();
      check("down_hold_pulse", move_pulse, exp_rpt(i) ? 4'b0100 : 4'b0000);
    end
    btn_raw = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step();
      check("glitch_pulse", move_pulse, 4'b0000);
    end
    btn_raw = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      step();
      check("glitch_after_pulse", move_pulse, 4'b0000);
      check("glitch_level", btn_level, 4'b0100);
    end
    release_all();

    // Mid-operation asynchronous reset
    btn_raw = 4'b0010;
    for (int i = 1; i <= 7; i++) step();
    check("pre_async_level", btn_level, 4'b0010);
    #2;
    rstn = 1'b0;
    #1;
    check("async_rst_level", btn_level, 4'b0000);
    check("async_rst_pulse", move_pulse, 4'b0000);
    btn_raw = 4'b0000;
    step();
    rstn = 1'b1;
    release_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
